// File: rtl/bit_deframer.sv
// Sync-word hunter and byte packer for a one-bit-per-beat AXIS stream.
// Locks on SYNC_WORD (within MAX_ERRS bit errors), then emits a fixed-length byte frame with tlast.
module bit_deframer #(
   parameter int          C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int          C_M00_AXIS_TDATA_WIDTH = 32,
   parameter logic [31:0] SYNC_WORD              = 32'h1ACFFC1D,
   parameter int          SYNC_LEN               = 32,
   parameter int          MAX_ERRS               = 0,
   parameter int          PAYLOAD_BYTES          = 16
) (
   input  logic                                  s00_axis_aclk,
   input  logic                                  s00_axis_aresetn,
   input  logic                                  s00_axis_tvalid,
   output logic                                  s00_axis_tready,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
   input  logic                                  s00_axis_tlast,
   input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
   output logic                                  m00_axis_tvalid,
   input  logic                                  m00_axis_tready,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
   output logic                                  m00_axis_tlast,
   output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
   output logic                                  locked,
   output logic [15:0]                           frame_count,
   output logic [5:0]                            sync_errs
);

   localparam logic [SYNC_LEN-1:0] SYNC_PAT  = SYNC_WORD[SYNC_LEN-1:0];
   localparam logic [5:0]          FILL_FULL = 6'(SYNC_LEN);
   localparam logic [5:0]          ERR_MAX   = 6'(MAX_ERRS);
   localparam logic [7:0]          LAST_IDX  = 8'(PAYLOAD_BYTES - 1);

   typedef enum logic {ST_HUNT, ST_PAYLOAD} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [SYNC_LEN-1:0] r_shreg;
   logic [5:0]          r_fill;
   logic [7:0]          r_pack;
   logic [2:0]          r_bitcnt;
   logic [7:0]          r_bytecnt;
   logic                r_tvalid;
   logic                r_tlast;
   logic [7:0]          r_tdata;
   logic                r_locked;
   logic [15:0]         r_frame_count;
   logic [5:0]          r_sync_errs;

   logic                w_bit;
   logic                w_in_hs;
   logic                w_out_hs;
   logic                w_hunt_hs;
   logic                w_pay_hs;
   logic [SYNC_LEN-1:0] w_shreg_nxt;
   logic [SYNC_LEN-1:0] w_diff;
   logic [5:0]          w_fill_nxt;
   logic [5:0]          w_dist;
   logic                w_match;
   logic [7:0]          w_pack_nxt;
   logic                w_byte_done;
   logic                w_last_byte;
   logic                w_unused;

   assign w_bit       = s00_axis_tdata[0];
   assign w_unused    = ^{s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:1], s00_axis_tlast, s00_axis_tstrb};

   // A pending output byte that is not being taken stalls the input in every state.
   assign s00_axis_tready = ~r_tvalid | m00_axis_tready;
   assign w_in_hs     = s00_axis_tvalid & s00_axis_tready;
   assign w_out_hs    = r_tvalid & m00_axis_tready;
   assign w_hunt_hs   = w_in_hs & (r_state == ST_HUNT);
   assign w_pay_hs    = w_in_hs & (r_state == ST_PAYLOAD);

   assign w_shreg_nxt = {r_shreg[SYNC_LEN-2:0], w_bit};
   assign w_diff      = w_shreg_nxt ^ SYNC_PAT;
   assign w_fill_nxt  = (r_fill == FILL_FULL) ? r_fill : r_fill + 6'd1;

   always_comb begin
      w_dist = '0;
      for (int i = 0; i < SYNC_LEN; i++) w_dist = w_dist + 6'(w_diff[i]);
   end

   assign w_match     = w_hunt_hs & (w_fill_nxt == FILL_FULL) & (w_dist <= ERR_MAX);
   assign w_pack_nxt  = {r_pack[6:0], w_bit};
   assign w_byte_done = w_pay_hs & (r_bitcnt == 3'd7);
   assign w_last_byte = w_byte_done & (r_bytecnt == LAST_IDX);

   always_ff @(posedge s00_axis_aclk) begin
      if (!s00_axis_aresetn) r_state <= ST_HUNT;
      else                   r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_HUNT:    if (w_match)     w_state_nxt = ST_PAYLOAD;
         ST_PAYLOAD: if (w_last_byte) w_state_nxt = ST_HUNT;
         default:                     w_state_nxt = ST_HUNT;
      endcase
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (!s00_axis_aresetn) begin
         r_shreg       <= '0;
         r_fill        <= '0;
         r_pack        <= '0;
         r_bitcnt      <= '0;
         r_bytecnt     <= '0;
         r_tvalid      <= 1'b0;
         r_tlast       <= 1'b0;
         r_tdata       <= '0;
         r_locked      <= 1'b0;
         r_frame_count <= '0;
         r_sync_errs   <= '0;
      end else begin
         if (w_byte_done) begin
            r_tvalid <= 1'b1;
            r_tlast  <= w_last_byte;
            r_tdata  <= w_pack_nxt;
         end else if (w_out_hs) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
         end
         r_locked <= (w_state_nxt == ST_PAYLOAD);
         if (w_hunt_hs) begin
            r_shreg <= w_shreg_nxt;
            r_fill  <= w_fill_nxt;
         end
         if (w_match) begin
            r_sync_errs <= w_dist;
            r_bitcnt    <= '0;
            r_bytecnt   <= '0;
         end
         if (w_pay_hs) begin
            r_pack   <= w_pack_nxt;
            r_bitcnt <= r_bitcnt + 3'd1;
         end
         if (w_byte_done) r_bytecnt <= r_bytecnt + 8'd1;
         // Emptying the hunt window forces SYNC_LEN fresh bits before the next lock.
         if (w_last_byte) begin
            r_frame_count <= r_frame_count + 16'd1;
            r_shreg       <= '0;
            r_fill        <= '0;
         end
      end
   end

   assign m00_axis_tvalid = r_tvalid;
   assign m00_axis_tlast  = r_tlast;
   assign m00_axis_tdata  = C_M00_AXIS_TDATA_WIDTH'(r_tdata);
   assign m00_axis_tstrb  = '1;
   assign locked          = r_locked;
   assign frame_count     = r_frame_count;
   assign sync_errs       = r_sync_errs;

endmodule

// File: tb/tb_bit_deframer.sv
// Scoreboard bench for bit_deframer: stimulus pushes expected bytes, a monitor pops them on each output handshake.
module tb_bit_deframer;
   localparam logic [31:0] SYNC = 32'h1ACFFC1D;

   logic        clk = 1'b0;
   logic        aresetn;
   logic        s_tvalid;
   logic        s_tready;
   logic [31:0] s_tdata;
   logic        s_tlast;
   logic [3:0]  s_tstrb;
   logic        m_tvalid;
   logic        m_tready = 1'b1;
   logic [31:0] m_tdata;
   logic        m_tlast;
   logic [3:0]  m_tstrb;
   logic        locked;
   logic [15:0] frame_count;
   logic [5:0]  sync_errs;

   typedef struct packed {
      logic [7:0] d;
      logic       last;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass    = 0;
   int   n_total   = 0;
   bit   rnd_valid = 1'b0;
   bit   rnd_ready = 1'b0;

   bit_deframer #(
      .C_S00_AXIS_TDATA_WIDTH(32),
      .C_M00_AXIS_TDATA_WIDTH(32),
      .SYNC_WORD             (SYNC),
      .SYNC_LEN              (32),
      .MAX_ERRS              (2),
      .PAYLOAD_BYTES         (16)
   ) dut (
      .s00_axis_aclk   (clk),
      .s00_axis_aresetn(aresetn),
      .s00_axis_tvalid (s_tvalid),
      .s00_axis_tready (s_tready),
      .s00_axis_tdata  (s_tdata),
      .s00_axis_tlast  (s_tlast),
      .s00_axis_tstrb  (s_tstrb),
      .m00_axis_tvalid (m_tvalid),
      .m00_axis_tready (m_tready),
      .m00_axis_tdata  (m_tdata),
      .m00_axis_tlast  (m_tlast),
      .m00_axis_tstrb  (m_tstrb),
      .locked          (locked),
      .frame_count     (frame_count),
      .sync_errs       (sync_errs)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   // Monitor: any output handshake must match the head of the scoreboard.
   always @(negedge clk) begin
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_byte: got 0x%0h, want no output", m_tdata);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("byte_data", m_tdata, {24'h0, e.d});
            chk("byte_last", 32'(m_tlast), 32'(e.last));
         end
      end
   end

   always @(posedge clk) begin
      #1;
      m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send_bit(input logic b);
      int   t  = 0;
      logic hs = 1'b0;
      while (rnd_valid && $urandom_range(0, 1) == 1) begin
         s_tvalid = 1'b0;
         @(posedge clk); #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = {31'b0, b};
      while (!hs && t < 1000) begin
         @(negedge clk);
         hs = s_tready;
         @(posedge clk); #1;
         t++;
      end
      s_tvalid = 1'b0;
      if (!hs) begin
         n_total++;
         $display("FAIL send_bit: input not accepted within 1000 cycles");
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 31; i >= 0; i--) send_bit(w[i]);
   endtask

   function automatic logic [7:0] pbyte(input int mode, input int i);
      case (mode)
         0:       return 8'(i);
         1:       return 8'hA0 + 8'(i);
         2:       return 8'(i * 17 + 3);
         3: case (i % 4)
               0:       return 8'h1A;
               1:       return 8'hCF;
               2:       return 8'hFC;
               default: return 8'h1D;
            endcase
         default: return 8'h55 ^ 8'(i);
      endcase
   endfunction

   // Sync word followed by nbytes payload bytes; a full frame marks byte 15 as last.
   task automatic send_frame(input logic [31:0] sw, input int mode, input int nbytes);
      for (int i = 0; i < nbytes; i++) exp_q.push_back('{pbyte(mode, i), (i == 15)});
      send_word(sw);
      chk("locked_after_sync", 32'(locked), 32'd1);
      for (int i = 0; i < nbytes; i++) send_byte(pbyte(mode, i));
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || m_tvalid === 1'b1) && t < 2000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      s_tvalid = 1'b0;
      aresetn  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      aresetn  = 1'b1;
   endtask

   initial begin
      logic [19:0] pre;
      aresetn  = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = 32'h1;
      s_tlast  = 1'b0;
      s_tstrb  = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_tlast", 32'(m_tlast), 32'd0);
      chk("rst_tdata", m_tdata, 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_frame_count", 32'(frame_count), 32'd0);
      chk("rst_sync_errs", 32'(sync_errs), 32'd0);
      chk("rst_s_tready", 32'(s_tready), 32'd1);
      chk("tstrb", 32'(m_tstrb), 32'hF);
      aresetn  = 1'b1;
      s_tvalid = 1'b0;

      // Clean lock after a noise prefix
      pre = 20'hB3E5A;
      for (int i = 19; i >= 0; i--) send_bit(pre[i]);
      chk("locked_in_prefix", 32'(locked), 32'd0);
      send_frame(SYNC, 0, 16);
      chk("clean_locked_end", 32'(locked), 32'd0);
      chk("clean_frame_count", 32'(frame_count), 32'd1);
      chk("clean_sync_errs", 32'(sync_errs), 32'd0);
      drain();

      // Two flipped sync bits: still locks
      do_reset();
      send_frame(SYNC ^ 32'h80000001, 4, 16);
      chk("tol2_sync_errs", 32'(sync_errs), 32'd2);
      chk("tol2_frame_count", 32'(frame_count), 32'd1);
      drain();

      // Three flipped sync bits: no lock, no output
      do_reset();
      send_word(SYNC ^ 32'h80010001);
      repeat (20) @(posedge clk);
      #1;
      chk("tol3_locked", 32'(locked), 32'd0);
      chk("tol3_tvalid", 32'(m_tvalid), 32'd0);
      chk("tol3_frame_count", 32'(frame_count), 32'd0);
      chk("tol3_sync_errs", 32'(sync_errs), 32'd0);

      // Back-to-back frames under random valid/ready
      do_reset();
      rnd_valid = 1'b1;
      rnd_ready = 1'b1;
      send_frame(SYNC, 1, 16);
      chk("b2b_frame_count_1", 32'(frame_count), 32'd1);
      send_frame(SYNC, 2, 16);
      chk("b2b_frame_count_2", 32'(frame_count), 32'd2);
      drain();
      rnd_valid = 1'b0;
      rnd_ready = 1'b0;
      @(posedge clk); #1;

      // Payload carrying the sync pattern is plain data
      do_reset();
      send_frame(SYNC, 3, 16);
      send_byte(8'h00);
      drain();
      chk("syncpay_frame_count", 32'(frame_count), 32'd1);
      chk("syncpay_locked", 32'(locked), 32'd0);

      // Reset after 5 payload bytes, then a clean frame
      do_reset();
      send_frame(SYNC, 0, 5);
      aresetn = 1'b0;
      @(posedge clk); #1;
      chk("midrst_tvalid", 32'(m_tvalid), 32'd0);
      chk("midrst_locked", 32'(locked), 32'd0);
      chk("midrst_frame_count", 32'(frame_count), 32'd0);
      chk("midrst_pending", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
      aresetn = 1'b1;
      send_frame(SYNC, 2, 16);
      drain();
      chk("midrst_next_frame_count", 32'(frame_count), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
